i2c_master_cmd_seq: RTL
=======================

Name: i2c_master_cmd_seq

Overview:
Upstream command sequencer for the Wishbone I2C master core. It accepts one register-level request (device address, register address, read or write) and issues the Wishbone accesses to the core's TXR/CR/SR/RXR registers. It polls transfer completion, checks ACK and arbitration-lost status, and returns one response. The core's control register resets enabled and its prescale is fixed, so the sequencer never writes PRER or CTR.

Parameters:
POLL_GAP, 2, idle cycles after every CR write before the first SR poll; minimum 2, because TIP lags the CR write by 2 cycles.
POLL_LIMIT, 65535, maximum SR reads per byte before a timeout error; counter width is $clog2(POLL_LIMIT+1).

Ports:
wb_clk_i  in  1  single clock
arst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_rw_i  in  1  1=read, 0=write
req_dev_i  in  7  7-bit I2C device address
req_reg_i  in  8  target register address
req_wdata_i  in  8  write data
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  8  read data; 0 for writes and errors
rsp_err_o  out  2  0=OK, 1=NACK, 2=ARB_LOST, 3=TIMEOUT
busy_o  out  1  high whenever not IDLE
wb_adr_o  out  3  core register address
wb_dat_o  out  8  write data to core
wb_dat_i  in  8  read data from core
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  core acknowledge

Behaviour:
- Reset (arst_ni=0, async): all outputs 0 except req_ready_o=1; state IDLE; counters cleared.
- Handshake: a request is accepted when req_valid_i & req_ready_o. Fields are captured on acceptance; input changes afterwards are ignored.
- Wishbone access:
  - cyc=stb held with a stable adr/we/dat until wb_ack_i.
  - On ack, cyc and stb drop the next cycle. At least one idle cycle follows before the next access, because the core's ack toggles if stb is held.
  - Read data is sampled on the ack cycle.
- Register map: TXR=3 (write), CR=4 (write), SR=4 (read), RXR=3 (read).
- CR values: STA|WR=0x90, WR=0x10, STO|WR=0x50, RD|NACK|STO=0x68, STO=0x40.
- Byte step = write TXR, write CR, wait POLL_GAP, then poll SR until SR[1] (TIP) is 0.
  - SR[5] (AL) set on any poll: rsp_err=2, go directly to RESP (no STO).
  - Poll count reaching POLL_LIMIT: write CR=0x40, rsp_err=3.
  - After TIP clears on a write byte, SR[7] (RXACK) set: write CR=0x40, rsp_err=1.
- Write sequence: {dev,0}/0x90 -> reg/0x10 -> wdata/0x50 -> RESP.
- Read sequence: {dev,0}/0x90 -> reg/0x10 -> {dev,1}/0x90 (repeated start) -> CR=0x68, poll (RXACK not checked) -> read RXR -> RESP.
- States: IDLE, WR_TXR, WR_CR, GAP, POLL, STOP, RD_RXR, RESP. A byte index (0..3) selects TXR/CR content.
- RESP: rsp_valid_o=1 for exactly one cycle with rdata and err, then IDLE. req_ready_o returns the cycle after RESP, so back-to-back requests take at least 1 IDLE cycle.
- Reset mid-transaction: cyc and stb drop immediately (async) and no response is issued. The core must be reset by its own reset.
- wb_ack_i outside an active access is ignored.

Decomposition:
- Package i2c_seq_pkg:
  - Register address localparams (TXR, CR, SR, RXR).
  - CR command constants.
  - SR bit indices.
  - Error enum err_e (OK, NACK, AL, TIMEOUT).
  - State enum state_e.
- Sub-module i2c_wb_access: a single-access Wishbone engine with start/we/adr/wdata in and done/rdata out. It owns the hold-until-ack and mandatory idle-cycle rule.

Test Plan:
- Write dev=0x50 reg=0x12 data=0xA5 with an ACKing slave model -> TXR writes 0xA0, 0x12, 0xA5; CR writes 0x90, 0x10, 0x50; rsp_err=0; exactly one rsp_valid pulse.
- Read dev=0x50 reg=0x34, slave returns 0x5C -> TXR 0xA0, 0x34, 0xA1; CR 0x90, 0x10, 0x90, 0x68; rsp_rdata=0x5C; rsp_err=0.
- Write to absent dev=0x2B (RXACK=1 on first byte) -> CR=0x40 issued, no further TXR writes, rsp_err=1.
- AL forced on second byte poll -> no STO written, rsp_err=2, back in IDLE, req_ready_o=1 next cycle.
- POLL_LIMIT=8, TIP stuck 1 -> exactly 8 SR reads then CR=0x40, rsp_err=3.
- Assert arst_ni during POLL -> wb_cyc_o and wb_stb_o 0 immediately, no rsp_valid; a new request completes normally afterwards. Also check for every access that wb_stb_o is never high on the cycle after an ack.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: register map, CR commands, SR bits and enums shared by the I2C command sequencer.
package i2c_seq_pkg;

    localparam logic [2:0] REG_TXR = 3'd3;
    localparam logic [2:0] REG_RXR = 3'd3;
    localparam logic [2:0] REG_CR  = 3'd4;
    localparam logic [2:0] REG_SR  = 3'd4;

    localparam logic [7:0] CMD_STA_WR      = 8'h90;
    localparam logic [7:0] CMD_WR          = 8'h10;
    localparam logic [7:0] CMD_STO_WR      = 8'h50;
    localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CMD_STO         = 8'h40;

    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_AL      = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_TXR = 3'd1,
        ST_WR_CR  = 3'd2,
        ST_GAP    = 3'd3,
        ST_POLL   = 3'd4,
        ST_STOP   = 3'd5,
        ST_RD_RXR = 3'd6,
        ST_RESP   = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_wb_access.sv
// i2c_wb_access: single Wishbone access engine; holds cyc/stb until ack, then forces one idle cycle.
module i2c_wb_access (
    input  logic       wb_clk_i,
    input  logic       arst_ni,
    input  logic       start,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    assign wb_stb_o = wb_cyc_o;

    // start is ignored during the done cycle, which doubles as the idle cycle between accesses
    always_ff @(posedge wb_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wb_cyc_o <= 1'b0;
            wb_adr_o <= 3'd0;
            wb_dat_o <= 8'd0;
            wb_we_o  <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'd0;
        end else begin
            done <= 1'b0;
            if (wb_cyc_o) begin
                if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    done     <= 1'b1;
                    if (!wb_we_o) rdata <= wb_dat_i;
                end
            end else if (start && !done) begin
                wb_cyc_o <= 1'b1;
                wb_adr_o <= adr;
                wb_dat_o <= wdata;
                wb_we_o  <= we;
            end
        end
    end

endmodule

// File: rtl/i2c_master_cmd_seq.sv
// i2c_master_cmd_seq: turns one register read/write request into TXR/CR/SR/RXR accesses on the I2C core.
module i2c_master_cmd_seq
    import i2c_seq_pkg::*;
#(
    parameter int POLL_GAP   = 2,
    parameter int POLL_LIMIT = 65535
) (
    input  logic       wb_clk_i,
    input  logic       arst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic       busy_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    localparam int CW = $clog2((POLL_LIMIT > POLL_GAP ? POLL_LIMIT : POLL_GAP) + 1);

    state_e      state;
    err_e        err_q;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic [1:0]  bi;
    logic [CW-1:0] cnt;
    logic        acc_start;
    logic        acc_we;
    logic        acc_done;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_wdata;
    logic [7:0]  acc_rdata;
    logic [7:0]  txr_byte;
    logic [7:0]  cr_byte;

    // byte 3 exists only for reads: receive with NACK+STO, no TXR write
    always_comb begin
        txr_byte  = bi == 2'd0 ? {dev_q, 1'b0} : bi == 2'd1 ? reg_q : rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte   = bi == 2'd0 ? CMD_STA_WR : bi == 2'd1 ? CMD_WR : bi == 2'd3 ? CMD_RD_NACK_STO :
                    rw_q ? CMD_STA_WR : CMD_STO_WR;
        acc_start = state inside {ST_WR_TXR, ST_WR_CR, ST_POLL, ST_STOP, ST_RD_RXR};
        acc_we    = state != ST_POLL && state != ST_RD_RXR;
        acc_adr   = state == ST_WR_TXR ? REG_TXR : state == ST_RD_RXR ? REG_RXR :
                    state == ST_POLL ? REG_SR : REG_CR;
        acc_wdata = state == ST_WR_TXR ? txr_byte : state == ST_STOP ? CMD_STO : cr_byte;
    end

    always_ff @(posedge wb_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= ST_IDLE;
            err_q   <= ERR_OK;
            rw_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            bi      <= 2'd0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid_i) begin
                    rw_q    <= req_rw_i;
                    dev_q   <= req_dev_i;
                    reg_q   <= req_reg_i;
                    wdata_q <= req_wdata_i;
                    rdata_q <= 8'd0;
                    err_q   <= ERR_OK;
                    bi      <= 2'd0;
                    cnt     <= '0;
                    state   <= ST_WR_TXR;
                end
                ST_WR_TXR: if (acc_done) state <= ST_WR_CR;
                ST_WR_CR: if (acc_done) begin
                    cnt   <= '0;
                    state <= ST_GAP;
                end
                ST_GAP: if (cnt == CW'(POLL_GAP - 1)) begin
                    cnt   <= '0;
                    state <= ST_POLL;
                end else cnt <= cnt + 1'b1;
                ST_POLL: if (acc_done) begin
                    if (acc_rdata[SR_AL]) begin
                        err_q <= ERR_AL;
                        state <= ST_RESP;
                    end else if (acc_rdata[SR_TIP]) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(POLL_LIMIT - 1)) begin
                            err_q <= ERR_TIMEOUT;
                            state <= ST_STOP;
                        end
                    end else if (bi == 2'd3) state <= ST_RD_RXR;
                    else if (acc_rdata[SR_RXACK]) begin
                        err_q <= ERR_NACK;
                        state <= ST_STOP;
                    end else if (!rw_q && bi == 2'd2) state <= ST_RESP;
                    else begin
                        bi    <= bi + 2'd1;
                        state <= bi == 2'd2 ? ST_WR_CR : ST_WR_TXR;
                    end
                end
                ST_STOP: if (acc_done) state <= ST_RESP;
                ST_RD_RXR: if (acc_done) begin
                    rdata_q <= acc_rdata;
                    state   <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = state == ST_IDLE;
    assign busy_o      = state != ST_IDLE;
    assign rsp_valid_o = state == ST_RESP;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 8'd0;
    assign rsp_err_o   = rsp_valid_o ? err_q : ERR_OK;

    i2c_wb_access u_acc (
        .wb_clk_i (wb_clk_i),
        .arst_ni  (arst_ni),
        .start    (acc_start),
        .we       (acc_we),
        .adr      (acc_adr),
        .wdata    (acc_wdata),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

endmodule
